instr_fetch_unit: RTL and testbench

- Produces the instruction word whose OP field [31:26] drives the opcode decoder.
- Consumes the decoder's Jump/BranchEQ/BranchNE outputs, plus the ALU Zero flag, to compute the next PC.
- Sits between instruction memory and decode in the multi-cycle MIPS core.
- Holds the PC, performs a valid/ack fetch from instruction memory, and presents one instruction at a time to decode.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/instr_fetch_unit_next_pc.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the multi-cycle MIPS core.
// FETCH_MISALIGN_TRAP_EN selects the misaligned-target trap in the fetch unit.
package mips_pkg;

  localparam logic [31:0] MARS_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] RESET_PC_DEF   = MARS_TEXT_BASE;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESOLVE,
    TRAP
  } fetch_state_t;

  function automatic logic [5:0] op_field(input logic [31:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection: JR, J, conditional branch, or fall-through.
// Produces the raw target; alignment handling lives in the fetch unit.
module next_pc_calc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [25:0]           imm,
  input  logic                  jump_reg,
  input  logic [DATA_WIDTH-1:0] reg_target,
  input  logic                  jump,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] target
);

  logic [DATA_WIDTH-1:0] br_off;
  logic [DATA_WIDTH-1:0] j_tgt;
  logic                  taken;

  assign pc_plus4 = pc + DATA_WIDTH'(4);

  // word offset, sign-extended then scaled by 4
  assign br_off = {{(DATA_WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign j_tgt  = {pc_plus4[DATA_WIDTH-1:28], imm, 2'b00};
  assign taken  = (branch_eq & zero) | (branch_ne & ~zero);

  always_comb begin
    target = pc_plus4;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = j_tgt;
    end else if (taken) begin
      target = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, imem valid/ack fetch and single-entry issue to decode.
// FETCH_MISALIGN_TRAP_EN: misaligned next_pc traps instead of being masked.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  resolve_valid,
  input  logic                  jump,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero,
  input  logic                  jump_reg,
  input  logic [DATA_WIDTH-1:0] reg_target,
  output logic                  fetch_fault
);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  misaligned;
  logic                  pc_load;
  logic                  instr_load;
  logic                  trap_set;

  next_pc_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_pc (
    .pc        (pc),
    .imm       (instr[25:0]),
    .jump_reg  (jump_reg),
    .reg_target(reg_target),
    .jump      (jump),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .zero      (zero),
    .pc_plus4  (pc_plus4),
    .target    (target)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |target[1:0];
  assign next_pc    = target;
`else
  assign misaligned = 1'b0;
  assign next_pc    = {target[DATA_WIDTH-1:2], 2'b00};
`endif

  always_comb begin
    state_nxt  = state;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    trap_set   = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_load = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (resolve_valid) begin
          if (misaligned) begin
            trap_set  = 1'b1;
            state_nxt = TRAP;
          end else begin
            pc_load   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load)    pc    <= next_pc;
      if (instr_load) instr <= imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_fault <= 1'b0;
    end else if (trap_set) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

  // request and valid follow the state so reset drops them at once
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign imem_addr   = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit.
// Reference model computes next PC from the MIPS control rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        resolve_valid = 1'b0;
  logic        jump = 1'b0;
  logic        branch_eq = 1'b0;
  logic        branch_ne = 1'b0;
  logic        zero = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        fetch_fault;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc_plus4     (pc_plus4),
    .resolve_valid(resolve_valid),
    .jump         (jump),
    .branch_eq    (branch_eq),
    .branch_ne    (branch_ne),
    .zero         (zero),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .fetch_fault  (fetch_fault)
  );

  function automatic logic [31:0] model_next(
    input logic [31:0] pc, input logic [31:0] w,
    input logic jr_i, input logic [31:0] rt_i,
    input logic j_i, input logic beq_i, input logic bne_i,
    input logic z_i);
    logic [31:0] p4;
    logic [31:0] t;
    longint      off;
    p4 = pc + 32'd4;
    if (jr_i) t = rt_i;
    else if (j_i) t = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    else if ((beq_i && z_i) || (bne_i && !z_i)) begin
      off = longint'($signed(w[15:0]));
      t = 32'(longint'(p4) + off * 4);
    end else t = p4;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    resolve_valid = 0; jump = 0; branch_eq = 0; branch_ne = 0;
    zero = 0; jump_reg = 0; reg_target = '0;
  endtask

  // one full FETCH/ISSUE/RESOLVE transaction, with ignored stray inputs
  task automatic run(
    input logic [31:0] w, input int d, input int rd,
    input logic jr_i, input logic [31:0] rt_i,
    input logic j_i, input logic beq_i, input logic bne_i, input logic z_i,
    output logic [31:0] addr, output logic [31:0] seen,
    output logic [31:0] p4, output int reqc,
    output bit hs, output bit drop, output bit to);
    int n;
    to = 0; hs = 1; drop = 1; reqc = 0; n = 0;
    addr = 'x; seen = 'x; p4 = 'x;
    while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
    if (imem_req !== 1'b1) begin to = 1; return; end
    addr = imem_addr;
    for (int i = 0; i < d; i++) begin
      instr_ready = 1; resolve_valid = 1; jump = 1;
      if (imem_req === 1'b1) reqc++;
      step();
    end
    instr_ready = 0; clear_ctl();
    imem_ack = 1; imem_rdata = w;
    if (imem_req === 1'b1) reqc++;
    step();
    imem_ack = 0; imem_rdata = $urandom;
    drop = (imem_req === 1'b0);
    seen = instr; p4 = pc_plus4;
    if (instr_valid !== 1'b1) hs = 0;
    for (int i = 0; i < rd; i++) begin
      resolve_valid = 1; jump_reg = 1; reg_target = $urandom;
      step();
      if (instr_valid !== 1'b1 || instr !== w) hs = 0;
    end
    clear_ctl();
    instr_ready = 1; step(); instr_ready = 0;
    if (instr_valid !== 1'b0) hs = 0;
    jump_reg = jr_i; reg_target = rt_i; jump = j_i;
    branch_eq = beq_i; branch_ne = bne_i; zero = z_i;
    resolve_valid = 1; step(); clear_ctl();
  endtask

  task automatic test_reset();
    reset = 0; clear_ctl();
    step(); step();
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else passes++;
    checks++; if (instr !== 32'h0) $display("FAIL rst_instr got %h want 0", instr); else passes++;
    checks++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fetch_fault); else passes++;
    checks++; if (imem_addr !== RPC) $display("FAIL rst_addr got %h want %h", imem_addr, RPC); else passes++;
    checks++; if (pc_plus4 !== RPC + 4) $display("FAIL rst_pc4 got %h want %h", pc_plus4, RPC + 4); else passes++;
    reset = 1; #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else passes++;
    exp_pc = RPC;
  endtask

  task automatic test_addi();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0000) $display("FAIL addi_addr got %h want 00400000", a); else passes++;
    checks++; if (s !== 32'h2008_0005) $display("FAIL addi_instr got %h want 20080005", s); else passes++;
    checks++; if (p !== 32'h0040_0004) $display("FAIL addi_pc4 got %h want 00400004", p); else passes++;
    checks++; if (!dr) $display("FAIL addi_req_drop got 1 want 0"); else passes++;
    checks++; if (!hs) $display("FAIL addi_handshake got 0 want 1"); else passes++;
    exp_pc = model_next(exp_pc, 32'h2008_0005, 0, 0, 0, 0, 0, 0);
    run(32'h0, 0, 0, 1, 32'h0040_0010, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0004) $display("FAIL seq_addr got %h want 00400004", a); else passes++;
    exp_pc = 32'h0040_0010;
  endtask

  task automatic test_branch();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h1109_FFFF, 0, 0, 0, 0, 0, 1, 0, 1, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== exp_pc) $display("FAIL beq_pc got %h want %h", a, exp_pc); else passes++;
    exp_pc = model_next(exp_pc, 32'h1109_FFFF, 0, 0, 0, 1, 0, 1);
    run(32'h1109_FFFF, 0, 0, 0, 0, 0, 1, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0010) $display("FAIL beq_taken got %h want 00400010", a); else passes++;
    exp_pc = model_next(exp_pc, 32'h1109_FFFF, 0, 0, 0, 1, 0, 0);
    run(32'h0, 0, 0, 1, RPC, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0014) $display("FAIL beq_not_taken got %h want 00400014", a); else passes++;
    exp_pc = RPC;
  endtask

  task automatic test_jump();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h0810_0008, 0, 0, 0, 0, 1, 0, 1, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0000) $display("FAIL j_pc got %h want 00400000", a); else passes++;
    exp_pc = model_next(exp_pc, 32'h0810_0008, 0, 0, 1, 0, 1, 0);
    run(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0020) $display("FAIL j_priority got %h want 00400020", a); else passes++;
    exp_pc = model_next(exp_pc, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h2009_0007, 3, 2, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== exp_pc) $display("FAIL stall_addr got %h want %h", a, exp_pc); else passes++;
    checks++; if (rc !== 4) $display("FAIL stall_req_cycles got %0d want 4", rc); else passes++;
    checks++; if (!hs) $display("FAIL stall_instr_stable got 0 want 1"); else passes++;
    checks++; if (!dr) $display("FAIL stall_req_drop got 1 want 0"); else passes++;
    exp_pc = model_next(exp_pc, 32'h2009_0007, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    exp_pc = 32'hFFFF_FFFC;
    run(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", a); else passes++;
    checks++; if (p !== 32'h0) $display("FAIL wrap_pc4 got %h want 0", p); else passes++;
    run(32'h0, 0, 0, 1, RPC, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0) $display("FAIL wrap_next got %h want 0", a); else passes++;
    exp_pc = RPC;
  endtask

  task automatic test_random();
    logic [31:0] a, s, p, w, rt; int rc; bit hs, dr, to;
    logic jr_i, j_i, beq_i, bne_i, z_i;
    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      jr_i = ($urandom_range(0, 5) == 0);
      rt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rt = rt & 32'hFFFF_FFFC;
`endif
      j_i = $urandom_range(0, 1); beq_i = $urandom_range(0, 1);
      bne_i = $urandom_range(0, 1); z_i = $urandom_range(0, 1);
      run(w, $urandom_range(0, 3), $urandom_range(0, 2), jr_i, rt,
          j_i, beq_i, bne_i, z_i, a, s, p, rc, hs, dr, to);
      checks++; if (to || a !== exp_pc) $display("FAIL rnd_addr[%0d] got %h want %h", k, a, exp_pc); else passes++;
      checks++; if (s !== w || p !== exp_pc + 4) $display("FAIL rnd_instr[%0d] got %h/%h want %h/%h", k, s, p, w, exp_pc + 4); else passes++;
      checks++; if (!hs || !dr) $display("FAIL rnd_handshake[%0d] got %b%b want 11", k, hs, dr); else passes++;
      exp_pc = model_next(exp_pc, w, jr_i, rt, j_i, beq_i, bne_i, z_i);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, s, p; int rc; bit hs, dr, to; int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
    step();
    reset = 0; #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL mid_req got %b want 0", imem_req); else passes++;
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL mid_stale_ack got %h/%b want 0/0", instr, instr_valid); else passes++;
    imem_ack = 0;
    reset = 1; #1;
    exp_pc = RPC;
    run(32'h2010_0001, 1, 0, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== RPC) $display("FAIL mid_restart_addr got %h want %h", a, RPC); else passes++;
    checks++; if (s !== 32'h2010_0001) $display("FAIL mid_restart_instr got %h want 20100001", s); else passes++;
    exp_pc = model_next(exp_pc, 32'h2010_0001, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    logic [31:0] a, s, p; int rc; bit hs, dr, to;
    run(32'h0, 0, 0, 1, 32'h0040_0002, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== exp_pc) $display("FAIL mis_pre_addr got %h want %h", a, exp_pc); else passes++;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (fetch_fault !== 1'b1) $display("FAIL mis_fault got %b want 1", fetch_fault); else passes++;
    step(); step(); step();
    checks++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1) $display("FAIL mis_trap_hold got %b/%b want 0/1", imem_req, fetch_fault); else passes++;
    reset = 0; step(); reset = 1; #1;
`else
    run(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, a, s, p, rc, hs, dr, to);
    checks++; if (to || a !== 32'h0040_0000) $display("FAIL mis_mask got %h want 00400000", a); else passes++;
    checks++; if (fetch_fault !== 1'b0) $display("FAIL mis_fault got %b want 0", fetch_fault); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
